pat_scan: RTL and testbench

Memory-mapped pattern-search engine that offloads the bit-pattern counting workload from the processor core. On `start` it reads a contiguous run of bytes from data memory at one byte per cycle. It counts occurrences of a PW-bit pattern three ways: within each byte, bytes containing at least one match, and across the whole bit stream including byte-crossing matches. It generalises that workload to any pattern width of 1..8, runtime length and base address, and an optional non-overlapping count mode.

---
 rtl/pat_scan.sv | 214 +++++++++++++++++++++
 tb/tb_pat_scan.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pat_scan.sv
// pat_scan: byte-streaming bit-pattern counter.
// Reads len bytes starting at base_addr, one per cycle. For a PW-bit pattern it
// counts in-byte matches, bytes holding a match, and matches over the whole
// MSB-first bit stream, including windows that straddle byte boundaries.
module pat_scan #(
  parameter int PW = 5,
  parameter int AW = 8,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [PW-1:0] pat,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   len,
  input  logic          nonovl,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rdata,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] cnt_inbyte,
  output logic [CW-1:0] cnt_bytes,
  output logic [CW-1:0] cnt_stream
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Per-byte result: in-byte count, any-match flag, stream count, and the
  // stream suppression count handed to the next byte.
  typedef struct packed {
    logic [3:0] inb;
    logic       any;
    logic [3:0] str;
    logic [3:0] skip;
  } byte_res_t;

  localparam logic [3:0]  SKIP_RELOAD = 4'(PW - 1);
  localparam logic [AW:0] LEN_ONE     = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  // Evaluates the 8 stream windows that end inside cur. Window q starts q bits
  // into the 16-bit {prev, cur} view shifted so its MSB lands at bit 7-q+PW-1;
  // only the low PW-1 bits of prev ever reach a window. Windows with
  // q >= PW-1 are exactly the in-byte windows, in MSB-first order.
  function automatic byte_res_t scan_byte(
    input logic [7:0]    prev,
    input logic [7:0]    cur,
    input logic [PW-1:0] p,
    input logic          greedy,
    input logic          first,
    input logic [3:0]    skip_in
  );
    logic [15:0] ext;
    logic [15:0] sh;
    logic        hit;
    logic        in_win;
    logic [3:0]  sk_s;
    logic [3:0]  sk_i;
    byte_res_t   r;
    ext  = {prev, cur};
    r    = '0;
    sk_s = skip_in;
    sk_i = 4'd0;
    for (int q = 0; q < 8; q++) begin
      sh     = ext >> (7 - q);
      hit    = (sh[PW-1:0] == p);
      in_win = (q >= PW - 1);
      if (!first || in_win) begin
        if (greedy && (sk_s != 4'd0)) begin
          sk_s = sk_s - 4'd1;
        end else if (hit) begin
          r.str = r.str + 4'd1;
          sk_s  = greedy ? SKIP_RELOAD : 4'd0;
        end else begin
          sk_s = sk_s;
        end
      end else begin
        sk_s = sk_s;
      end
      if (in_win) begin
        r.any = r.any | hit;
        if (greedy && (sk_i != 4'd0)) begin
          sk_i = sk_i - 4'd1;
        end else if (hit) begin
          r.inb = r.inb + 4'd1;
          sk_i  = greedy ? SKIP_RELOAD : 4'd0;
        end else begin
          sk_i = sk_i;
        end
      end else begin
        sk_i = sk_i;
      end
    end
    r.skip = sk_s;
    return r;
  endfunction

  // Saturating accumulate: sticks at all-ones instead of wrapping.
  function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a, input logic [3:0] b);
    logic [CW:0] s;
    s = {1'b0, a} + {{(CW-3){1'b0}}, b};
    if (s[CW]) begin
      return {CW{1'b1}};
    end else begin
      return s[CW-1:0];
    end
  endfunction

  state_t        state_r;
  logic [AW:0]   rem_r;      // reads still to issue after the current one
  logic          valid_r;    // mem_rdata carries a byte this cycle
  logic          first_r;    // the arriving byte is byte 0
  logic [7:0]    carry_r;    // previous byte; its low PW-1 bits feed crossing windows
  logic [3:0]    skip_r;     // greedy stream suppression carried across bytes
  logic [PW-1:0] pat_r;
  logic          nonovl_r;
  byte_res_t     res_s;

  // Score the byte currently on mem_rdata.
  always_comb begin
    res_s = scan_byte(carry_r, mem_rdata, pat_r, nonovl_r, first_r, skip_r);
  end

  // Control FSM, read issue and pipelined accumulation; all outputs registered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= S_IDLE;
      rem_r      <= '0;
      valid_r    <= 1'b0;
      first_r    <= 1'b0;
      carry_r    <= 8'd0;
      skip_r     <= 4'd0;
      pat_r      <= '0;
      nonovl_r   <= 1'b0;
      mem_rd     <= 1'b0;
      mem_addr   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cnt_inbyte <= '0;
      cnt_bytes  <= '0;
      cnt_stream <= '0;
    end else begin
      valid_r <= mem_rd;
      if (valid_r) begin
        cnt_inbyte <= sat_add(cnt_inbyte, res_s.inb);
        cnt_bytes  <= sat_add(cnt_bytes, {3'd0, res_s.any});
        cnt_stream <= sat_add(cnt_stream, res_s.str);
        skip_r     <= res_s.skip;
        carry_r    <= mem_rdata;
        first_r    <= 1'b0;
      end else begin
        skip_r <= skip_r;
      end
      case (state_r)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            pat_r      <= pat;
            nonovl_r   <= nonovl;
            cnt_inbyte <= '0;
            cnt_bytes  <= '0;
            cnt_stream <= '0;
            skip_r     <= 4'd0;
            carry_r    <= 8'd0;
            first_r    <= 1'b1;
            busy       <= 1'b1;
            mem_addr   <= base_addr;
            if (len != '0) begin
              state_r <= S_READ;
              mem_rd  <= 1'b1;
              rem_r   <= len - LEN_ONE;
            end else begin
              state_r <= S_DONE;
              done    <= 1'b1;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        S_READ: begin
          if (rem_r == '0) begin
            mem_rd  <= 1'b0;
            state_r <= S_DRAIN;
          end else begin
            rem_r    <= rem_r - LEN_ONE;
            mem_addr <= mem_addr + ADDR_ONE;
          end
        end
        S_DRAIN: begin
          state_r <= S_DONE;
          done    <= 1'b1;
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
          mem_rd  <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pat_scan.sv
// Self-checking bench for pat_scan: directed cases plus randomized scans,
// compared against a bit-list reference model of the counting rules.
module tb_pat_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [7:0] base_addr;
  logic [8:0] len;
  logic       nonovl;
  logic       start5, start8;
  logic [4:0] pat5;
  logic [7:0] pat8;

  logic        rd_a, rd_s, rd_e;
  logic [7:0]  addr_a, addr_s, addr_e;
  logic [7:0]  rdata_a, rdata_s, rdata_e;
  logic        busy_a, busy_s, busy_e;
  logic        done_a, done_s, done_e;
  logic [15:0] ci_a, cb_a, cs_a;
  logic [5:0]  ci_s, cb_s, cs_s;
  logic [15:0] ci_e, cb_e, cs_e;

  logic [7:0] mem [0:255];

  int total = 0;
  int bad   = 0;

  pat_scan #(.PW(5), .AW(8), .CW(16)) dut_a (
    .clk(clk), .reset(reset), .start(start5), .pat(pat5), .base_addr(base_addr),
    .len(len), .nonovl(nonovl), .mem_rd(rd_a), .mem_addr(addr_a), .mem_rdata(rdata_a),
    .busy(busy_a), .done(done_a), .cnt_inbyte(ci_a), .cnt_bytes(cb_a), .cnt_stream(cs_a));

  // Same pattern width with narrow counters, to exercise saturation.
  pat_scan #(.PW(5), .AW(8), .CW(6)) dut_s (
    .clk(clk), .reset(reset), .start(start5), .pat(pat5), .base_addr(base_addr),
    .len(len), .nonovl(nonovl), .mem_rd(rd_s), .mem_addr(addr_s), .mem_rdata(rdata_s),
    .busy(busy_s), .done(done_s), .cnt_inbyte(ci_s), .cnt_bytes(cb_s), .cnt_stream(cs_s));

  pat_scan #(.PW(8), .AW(8), .CW(16)) dut_e (
    .clk(clk), .reset(reset), .start(start8), .pat(pat8), .base_addr(base_addr),
    .len(len), .nonovl(nonovl), .mem_rd(rd_e), .mem_addr(addr_e), .mem_rdata(rdata_e),
    .busy(busy_e), .done(done_e), .cnt_inbyte(ci_e), .cnt_bytes(cb_e), .cnt_stream(cs_e));

  // Data memory: one-cycle read latency for each engine.
  always @(posedge clk) begin
    if (rd_a) rdata_a <= mem[addr_a];
    if (rd_s) rdata_s <= mem[addr_s];
    if (rd_e) rdata_e <= mem[addr_e];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: lay the bytes out as a bit list and count windows directly.
  task automatic model(input int pw, input logic [7:0] p, input bit no, input int n,
                       input logic [7:0] b, output int ei, output int eb, output int es);
    bit bits [0:2047];
    logic [7:0] v, a, sh;
    int nxt, ov, gr;
    bit m;
    ei = 0; eb = 0; es = 0;
    for (int i = 0; i < n; i++) begin
      a = b + 8'(i);
      v = mem[a];
      for (int j = 0; j < 8; j++) bits[8*i+j] = v[7-j];
    end
    nxt = 0;
    for (int pos = 0; pos + pw <= 8*n; pos++) begin
      m = 1'b1;
      for (int t = 0; t < pw; t++) begin
        sh = p >> (pw - 1 - t);
        if (bits[pos+t] != sh[0]) m = 1'b0;
      end
      if (m && (!no || pos >= nxt)) begin
        es++;
        nxt = pos + pw;
      end
    end
    for (int i = 0; i < n; i++) begin
      ov = 0; gr = 0; nxt = 8*i;
      for (int pos = 8*i; pos <= 8*i + 8 - pw; pos++) begin
        m = 1'b1;
        for (int t = 0; t < pw; t++) begin
          sh = p >> (pw - 1 - t);
          if (bits[pos+t] != sh[0]) m = 1'b0;
        end
        if (m) begin
          ov++;
          if (pos >= nxt) begin
            gr++;
            nxt = pos + pw;
          end
        end
      end
      ei += no ? gr : ov;
      if (ov > 0) eb++;
    end
  endtask

  // One scan: checks read strobes/addresses, busy, done cycle, counts and hold.
  task automatic run(input bit wide, input logic [7:0] p, input int n, input logic [7:0] b,
                     input bit no, input bit repulse, input string name,
                     output int gi, output int gb, output int gs);
    int ei, eb, es, dcyc, bad_t;
    logic rd, dn, bz;
    logic [7:0] ad, ea;
    logic [15:0] ci, cb, cs;
    model(wide ? 8 : 5, p, no, n, b, ei, eb, es);
    dcyc = (n == 0) ? 1 : n + 2;
    bad_t = 0; gi = -1; gb = -1; gs = -1;
    @(negedge clk);
    base_addr = b; len = 9'(n); nonovl = no;
    if (wide) begin pat8 = p; start8 = 1'b1; end
    else begin pat5 = p[4:0]; start5 = 1'b1; end
    @(posedge clk);
    for (int cyc = 1; cyc <= dcyc + 1; cyc++) begin
      @(negedge clk);
      start5 = 1'b0; start8 = 1'b0;
      rd = wide ? rd_e : rd_a;     ad = wide ? addr_e : addr_a;
      dn = wide ? done_e : done_a; bz = wide ? busy_e : busy_a;
      ci = wide ? ci_e : ci_a; cb = wide ? cb_e : cb_a; cs = wide ? cs_e : cs_a;
      ea = b + 8'(cyc - 1);
      if (rd !== ((n != 0) && (cyc <= n))) bad_t++;
      if (rd === 1'b1 && ad !== ea) bad_t++;
      if (dn !== (cyc == dcyc)) bad_t++;
      if (bz !== (cyc <= dcyc)) bad_t++;
      if (cyc == dcyc) begin
        gi = int'(ci); gb = int'(cb); gs = int'(cs);
        if (!wide) begin
          check({name, "_sat_inb"}, 32'(ci_s), 32'((ei > 63) ? 63 : ei));
          check({name, "_sat_byt"}, 32'(cb_s), 32'((eb > 63) ? 63 : eb));
          check({name, "_sat_str"}, 32'(cs_s), 32'((es > 63) ? 63 : es));
        end
      end
      if (cyc == dcyc + 1) begin
        if (int'(ci) != gi || int'(cb) != gb || int'(cs) != gs) bad_t++;
      end
      if (repulse && cyc == 3) begin
        pat5 = ~p[4:0]; nonovl = ~no; base_addr = b + 8'd7; len = 9'd1; start5 = 1'b1;
      end
    end
    check({name, "_timing"}, 32'(bad_t), 32'd0);
    check({name, "_inb"}, 32'(gi), 32'(ei));
    check({name, "_byt"}, 32'(gb), 32'(eb));
    check({name, "_str"}, 32'(gs), 32'(es));
  endtask

  task automatic fill_const(input logic [7:0] v);
    for (int i = 0; i < 256; i++) mem[i] = v;
  endtask

  initial begin
    int gi, gb, gs, dones;
    logic [7:0] pick [0:5];
    logic [7:0] pb;
    int mode;
    pick[0] = 8'h00; pick[1] = 8'hFF; pick[2] = 8'h55;
    pick[3] = 8'hAA; pick[4] = 8'hA5; pick[5] = 8'h5A;
    reset = 1'b0; start5 = 1'b0; start8 = 1'b0; pat5 = 5'd0; pat8 = 8'd0;
    base_addr = 8'd0; len = 9'd0; nonovl = 1'b0;
    fill_const(8'h00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rd", 32'(rd_a), 32'd0);
    check("rst_addr", 32'(addr_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_cnt", 32'({ci_a, cb_a} | 32'(cs_a)), 32'd0);
    reset = 1'b1;

    run(1'b0, 8'h00, 32, 8'h00, 1'b0, 1'b0, "zeros", gi, gb, gs);
    check("zeros_k_inb", 32'(gi), 32'd128);
    check("zeros_k_str", 32'(gs), 32'd252);

    fill_const(8'h55);
    run(1'b0, 8'h15, 32, 8'h00, 1'b0, 1'b0, "alt_ov", gi, gb, gs);
    check("alt_ov_k", 32'({8'(gi), 8'(gb), 8'(gs)}), 32'({8'd64, 8'd32, 8'd126}));
    run(1'b0, 8'h15, 32, 8'h00, 1'b1, 1'b0, "alt_no", gi, gb, gs);
    check("alt_no_k", 32'({8'(gi), 8'(gb), 8'(gs)}), 32'({8'd32, 8'd32, 8'd42}));

    mem[8'h40] = 8'h07; mem[8'h41] = 8'hC0;
    run(1'b0, 8'h1F, 2, 8'h40, 1'b0, 1'b0, "cross", gi, gb, gs);
    check("cross_k", 32'({8'(gi), 8'(gb), 8'(gs)}), 32'({8'd0, 8'd0, 8'd1}));

    run(1'b0, 8'h15, 0, 8'h10, 1'b0, 1'b0, "len0", gi, gb, gs);
    mem[8'hFF] = 8'hF8; mem[8'h00] = 8'h3E;
    run(1'b0, 8'h1F, 2, 8'hFF, 1'b1, 1'b0, "wrap", gi, gb, gs);

    fill_const(8'h55);
    run(1'b0, 8'h15, 20, 8'h30, 1'b0, 1'b1, "repulse", gi, gb, gs);

    mem[8'h80] = 8'hA5; mem[8'h81] = 8'hA5; mem[8'h82] = 8'h00; mem[8'h83] = 8'hA5;
    run(1'b1, 8'hA5, 4, 8'h80, 1'b0, 1'b0, "pw8", gi, gb, gs);
    check("pw8_k", 32'({8'(gi), 8'(gb), 8'(gs)}), 32'({8'd3, 8'd3, 8'd3}));

    // Abort by reset in cycle 10 of a 32-byte scan.
    fill_const(8'h00);
    @(negedge clk);
    base_addr = 8'd0; len = 9'd32; nonovl = 1'b0; pat5 = 5'd0; start5 = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      start5 = 1'b0;
    end
    reset = 1'b0;
    @(negedge clk);
    check("abort_rd", 32'(rd_a), 32'd0);
    check("abort_addr", 32'(addr_a), 32'd0);
    check("abort_busy", 32'(busy_a), 32'd0);
    check("abort_cnt", 32'({ci_a, cb_a} | 32'(cs_a)), 32'd0);
    reset = 1'b1;
    dones = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (done_a === 1'b1 || busy_a === 1'b1) dones++;
    end
    check("abort_nodone", 32'(dones), 32'd0);
    run(1'b0, 8'h00, 32, 8'h00, 1'b0, 1'b0, "post_abort", gi, gb, gs);

    // Randomized scans.
    for (int r = 0; r < 18; r++) begin
      mode = $urandom_range(0, 2);
      pb = pick[$urandom_range(0, 5)];
      for (int i = 0; i < 256; i++) begin
        if (mode == 0) mem[i] = 8'($urandom);
        else if (mode == 1) mem[i] = pick[$urandom_range(0, 5)];
        else mem[i] = pb;
      end
      if (r < 14) begin
        run(1'b0, 8'($urandom_range(0, 31)), (r == 3) ? 256 : int'($urandom_range(0, 40)),
            8'($urandom), 1'($urandom), 1'b0, $sformatf("rnd%0d", r), gi, gb, gs);
      end else begin
        run(1'b1, pick[$urandom_range(0, 5)], int'($urandom_range(1, 40)),
            8'($urandom), 1'($urandom), 1'b0, $sformatf("rnd8_%0d", r), gi, gb, gs);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
